// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types and constants used by the memory arbiter.
package cpu_types_pkg;

  // Word width used for addresses and data on the memory side.
  localparam int WORD_W = 32;

  // Default cap on consecutive data grants while a fetch is waiting.
  localparam int MAX_DSTREAK_DEFAULT = 4;

  // Arbiter grant state: nobody, instruction fetch, or data access.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the arbiter's datapath-side and RAM-side signals.
interface mem_arbiter_if #(
  parameter int DATA_W = 32
);
  // datapath side
  logic              iREN;
  logic [DATA_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [DATA_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  // RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [DATA_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport dp (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, iload, dhit, dload
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ram_ready
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data accesses.
// Data wins ties, but a streak counter forces a fetch grant after
// MAX_DSTREAK back-to-back data grants while a fetch is pending.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DATA_W      = WORD_W,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [DATA_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [DATA_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t    state_reg, state_next;
  logic [SW-1:0] streak_reg, streak_next;
  logic          dreq;

  assign dreq = dREN | dWEN;

  // State and streak registers; reset aborts any transaction at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      streak_reg <= '0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
    end
  end

  // Arbitration, grant outputs and streak bookkeeping.
  always_comb begin
    state_next  = state_reg;
    streak_next = streak_reg;
    ihit        = 1'b0;
    dhit        = 1'b0;
    iload       = '0;
    dload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_reg)
      IDLE: begin
        // data first, unless the waiting fetch has been passed over enough
        if (dreq && !(iREN && streak_reg == STREAK_MAX)) begin
          state_next = DGNT;
        end else if (iREN) begin
          state_next = IGNT;
        end
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        if (!iREN) begin
          // requester gave up: abort, no hit, streak untouched
          state_next = IDLE;
        end else if (ram_ready) begin
          ihit        = 1'b1;
          state_next  = IDLE;
          streak_next = '0;
        end
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        if (!dreq) begin
          state_next = IDLE;
        end else if (ram_ready) begin
          dhit       = 1'b1;
          state_next = IDLE;
          if (!iREN) begin
            streak_next = '0;
          end else if (streak_reg != STREAK_MAX) begin
            streak_next = streak_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
